// File: rtl/count_watch_pkg.sv
// Shared types and default widths for the count_watch block.
package count_watch_pkg;

  localparam int unsigned CNT_W_DEF  = 4;
  localparam int unsigned WRAP_W_DEF = 8;
  localparam int unsigned EVT_CODE_W = 2;

  typedef enum logic [1:0] {
    EVT_NONE  = 2'b00,
    EVT_MATCH = 2'b01,
    EVT_WRAP  = 2'b10,
    EVT_BOTH  = 2'b11
  } evt_code_t;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b10
  } buf_state_t;

endpackage

// File: rtl/count_watch_evtbuf.sv
// Two-entry valid/ready event buffer; head entry drives the outputs directly from registers.
module count_watch_evtbuf
  import count_watch_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_vld,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_vld,
  input  logic              out_rdy,
  output logic [DATA_W-1:0] out_data,
  output logic              ovf
);

  buf_state_t        state;
  logic [DATA_W-1:0] tail;
  logic              pop_c;

  assign pop_c = out_vld & out_rdy;

  // out_data is the head slot, tail is the second slot; a push into FULL without a pop is dropped
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= EMPTY;
      out_vld  <= 1'b0;
      out_data <= '0;
      tail     <= '0;
      ovf      <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (in_vld) begin
            out_data <= in_data;
            out_vld  <= 1'b1;
            state    <= ONE;
          end
        end
        ONE: begin
          if (in_vld && !pop_c) begin
            tail  <= in_data;
            state <= FULL;
          end else if (in_vld && pop_c) begin
            out_data <= in_data;
          end else if (pop_c) begin
            out_vld <= 1'b0;
            state   <= EMPTY;
          end
        end
        FULL: begin
          if (pop_c) begin
            out_data <= tail;
            if (in_vld) begin
              tail <= in_data;
            end else begin
              state <= ONE;
            end
          end else if (in_vld) begin
            ovf <= 1'b1;
          end
        end
        default: begin
          state   <= EMPTY;
          out_vld <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/count_watch.sv
// Count stream watcher: wrap/match detection, saturating wrap tally, buffered event output.
// Optional sequence checker enabled by defining COUNT_WATCH_SEQ_CHK_EN.
module count_watch
  import count_watch_pkg::*;
#(
  parameter int unsigned CNT_W  = CNT_W_DEF,
  parameter int unsigned WRAP_W = WRAP_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [CNT_W-1:0]  cnt_i,
  input  logic              cnt_vld_i,
  input  logic              match_en_i,
  input  logic [CNT_W-1:0]  match_val_i,
  output logic              evt_vld_o,
  input  logic              evt_rdy_i,
  output logic [1:0]        evt_code_o,
  output logic [CNT_W-1:0]  evt_cnt_o,
  output logic [WRAP_W-1:0] evt_wrap_o,
  output logic [WRAP_W-1:0] wrap_tally_o,
  output logic              ovf_o
`ifdef COUNT_WATCH_SEQ_CHK_EN
  ,
  output logic              seq_err_o
`endif
);

  localparam int unsigned PAY_W = EVT_CODE_W + CNT_W + WRAP_W;

  logic [CNT_W-1:0]  prev;
  logic              prev_vld;
  logic              wrap_c;
  logic              match_c;
  logic [WRAP_W-1:0] tally_next_c;
  evt_code_t         code_c;
  logic [PAY_W-1:0]  push_data_c;
  logic [PAY_W-1:0]  head_data;

  assign wrap_c  = cnt_vld_i && prev_vld && (prev == {CNT_W{1'b1}}) && (cnt_i == '0);
  assign match_c = cnt_vld_i && match_en_i && (cnt_i == match_val_i)
                   && (!prev_vld || (prev != cnt_i));

  assign tally_next_c = (wrap_c && (wrap_tally_o != {WRAP_W{1'b1}}))
                        ? WRAP_W'(wrap_tally_o + WRAP_W'(1)) : wrap_tally_o;

  assign code_c      = evt_code_t'({wrap_c, match_c});
  assign push_data_c = {code_c, cnt_i, tally_next_c};

  // Sample history and live tally
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev         <= '0;
      prev_vld     <= 1'b0;
      wrap_tally_o <= '0;
    end else if (cnt_vld_i) begin
      prev         <= cnt_i;
      prev_vld     <= 1'b1;
      wrap_tally_o <= tally_next_c;
    end
  end

`ifdef COUNT_WATCH_SEQ_CHK_EN
  logic seq_bad_c;

  // Legal steps: hold, +1 modulo 2^CNT_W, or restart to zero
  assign seq_bad_c = cnt_vld_i && prev_vld && (cnt_i != prev)
                     && (cnt_i != CNT_W'(prev + CNT_W'(1))) && (cnt_i != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seq_err_o <= 1'b0;
    end else if (seq_bad_c) begin
      seq_err_o <= 1'b1;
    end
  end
`endif

  count_watch_evtbuf #(
    .DATA_W (PAY_W)
  ) u_evtbuf (
    .clk      (clk),
    .reset    (reset),
    .in_vld   (wrap_c | match_c),
    .in_data  (push_data_c),
    .out_vld  (evt_vld_o),
    .out_rdy  (evt_rdy_i),
    .out_data (head_data),
    .ovf      (ovf_o)
  );

  assign evt_code_o = head_data[PAY_W-1 -: EVT_CODE_W];
  assign evt_cnt_o  = head_data[WRAP_W +: CNT_W];
  assign evt_wrap_o = head_data[WRAP_W-1:0];

endmodule

// File: tb/tb_count_watch.sv
// Self-checking bench for count_watch: queue-based reference model plus directed literal checks.
module tb_count_watch;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] cnt_i;
  logic       cnt_vld_i;
  logic       match_en_i;
  logic [3:0] match_val_i;
  logic       evt_rdy_i;
  logic       evt_vld_o;
  logic [1:0] evt_code_o;
  logic [3:0] evt_cnt_o;
  logic [7:0] evt_wrap_o;
  logic [7:0] wrap_tally_o;
  logic       ovf_o;
`ifdef COUNT_WATCH_SEQ_CHK_EN
  logic       seq_err_o;
`endif

  count_watch dut (
    .clk          (clk),
    .reset        (reset),
    .cnt_i        (cnt_i),
    .cnt_vld_i    (cnt_vld_i),
    .match_en_i   (match_en_i),
    .match_val_i  (match_val_i),
    .evt_vld_o    (evt_vld_o),
    .evt_rdy_i    (evt_rdy_i),
    .evt_code_o   (evt_code_o),
    .evt_cnt_o    (evt_cnt_o),
    .evt_wrap_o   (evt_wrap_o),
    .wrap_tally_o (wrap_tally_o),
    .ovf_o        (ovf_o)
`ifdef COUNT_WATCH_SEQ_CHK_EN
    ,
    .seq_err_o    (seq_err_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int code;
    int cnt;
    int wrap;
  } ev_t;

  ev_t m_q[$];
  int  m_prev;
  bit  m_prev_vld;
  int  m_tally;
  bit  m_ovf;
  bit  m_seq;
  bit  started = 1'b0;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_q.delete();
    m_prev     = 0;
    m_prev_vld = 1'b0;
    m_tally    = 0;
    m_ovf      = 1'b0;
    m_seq      = 1'b0;
  endtask

  // Apply one clock edge worth of behaviour using the inputs held across that edge
  task automatic model_update();
    int  c;
    int  old_size;
    bit  popped;
    bit  wrap;
    bit  match;
    ev_t e;
    c        = int'(cnt_i);
    old_size = m_q.size();
    popped   = (old_size > 0) && evt_rdy_i;
    if (popped) void'(m_q.pop_front());
    wrap  = cnt_vld_i && m_prev_vld && (m_prev == 15) && (c == 0);
    match = cnt_vld_i && match_en_i && (c == int'(match_val_i))
            && (!m_prev_vld || (m_prev != c));
    if (wrap && m_tally < 255) m_tally++;
    if (wrap || match) begin
      if (old_size < 2 || popped) begin
        e.code = (wrap ? 2 : 0) + (match ? 1 : 0);
        e.cnt  = c;
        e.wrap = m_tally;
        m_q.push_back(e);
      end else begin
        m_ovf = 1'b1;
      end
    end
    if (cnt_vld_i && m_prev_vld && c != m_prev && c != (m_prev + 1) % 16 && c != 0)
      m_seq = 1'b1;
    if (cnt_vld_i) begin
      m_prev     = c;
      m_prev_vld = 1'b1;
    end
  endtask

  // Compare DUT against the model on every falling edge
  always @(negedge clk) begin
    if (started) begin
      check("evt_vld", int'(evt_vld_o), int'(m_q.size() > 0));
      if (m_q.size() > 0) begin
        check("evt_code", int'(evt_code_o), m_q[0].code);
        check("evt_cnt", int'(evt_cnt_o), m_q[0].cnt);
        check("evt_wrap", int'(evt_wrap_o), m_q[0].wrap);
      end
      check("wrap_tally", int'(wrap_tally_o), m_tally);
      check("ovf", int'(ovf_o), int'(m_ovf));
`ifdef COUNT_WATCH_SEQ_CHK_EN
      check("seq_err", int'(seq_err_o), int'(m_seq));
`endif
    end
  end

  task automatic step(input int c, input bit v);
    cnt_i     = 4'(c);
    cnt_vld_i = v;
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic run(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) step(i, 1'b1);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset       = 1'b1;
    cnt_i       = '0;
    cnt_vld_i   = 1'b0;
    match_en_i  = 1'b0;
    match_val_i = '0;
    evt_rdy_i   = 1'b1;
    model_reset();
    started = 1'b1;
    #20;
    check("reset_vld", int'(evt_vld_o), 0);
    check("reset_tally", int'(wrap_tally_o), 0);
    reset = 1'b0;

    // Free run 0..15,0: one wrap event
    run(0, 15);
    step(0, 1'b1);
    check("wrap1_vld", int'(evt_vld_o), 1);
    check("wrap1_code", int'(evt_code_o), 2);
    check("wrap1_cnt", int'(evt_cnt_o), 0);
    check("wrap1_wrap", int'(evt_wrap_o), 1);
    check("wrap1_tally", int'(wrap_tally_o), 1);
    step(1, 1'b1);
    check("wrap1_drained", int'(evt_vld_o), 0);

    // Compare match at 5, held value must not re-fire
    match_en_i  = 1'b1;
    match_val_i = 4'd5;
    run(2, 5);
    check("match_vld", int'(evt_vld_o), 1);
    check("match_code", int'(evt_code_o), 1);
    check("match_cnt", int'(evt_cnt_o), 5);
    step(5, 1'b1);
    check("match_hold_no_refire", int'(evt_vld_o), 0);
    step(6, 1'b1);

    // Match on 0 coincident with wrap
    match_val_i = 4'd0;
    run(7, 15);
    step(0, 1'b1);
    check("both_code", int'(evt_code_o), 3);
    check("both_wrap", int'(evt_wrap_o), 2);
    step(1, 1'b1);

    // Three wraps with ready low: third one dropped
    match_en_i = 1'b0;
    evt_rdy_i  = 1'b0;
    run(2, 15);
    step(0, 1'b1);
    run(1, 15);
    step(0, 1'b1);
    run(1, 15);
    step(0, 1'b1);
    check("full_head_wrap", int'(evt_wrap_o), 3);
    check("full_ovf", int'(ovf_o), 1);
    check("full_tally", int'(wrap_tally_o), 5);
    evt_rdy_i = 1'b1;
    step(0, 1'b0);
    check("drain_second_vld", int'(evt_vld_o), 1);
    check("drain_second_wrap", int'(evt_wrap_o), 4);
    step(0, 1'b0);
    check("drain_empty", int'(evt_vld_o), 0);

    // Fill buffer, then reset asynchronously mid-cycle
    evt_rdy_i = 1'b0;
    run(1, 15);
    step(0, 1'b1);
    run(1, 15);
    step(0, 1'b1);
    run(1, 15);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check("rst_mid_vld", int'(evt_vld_o), 0);
    check("rst_mid_tally", int'(wrap_tally_o), 0);
    check("rst_mid_ovf", int'(ovf_o), 0);
    @(negedge clk);
    reset     = 1'b0;
    evt_rdy_i = 1'b1;
    step(0, 1'b1);
    check("post_rst_no_wrap", int'(evt_vld_o), 0);
    check("post_rst_tally", int'(wrap_tally_o), 0);

    // Sequence checking: 2,3,7 is illegal; 9,0 is a legal restart
    pulse_reset();
    step(2, 1'b1);
    step(3, 1'b1);
    step(7, 1'b1);
`ifdef COUNT_WATCH_SEQ_CHK_EN
    check("seq_jump", int'(seq_err_o), 1);
`endif
    pulse_reset();
    step(9, 1'b1);
    step(0, 1'b1);
    check("restart_no_evt", int'(evt_vld_o), 0);
`ifdef COUNT_WATCH_SEQ_CHK_EN
    check("seq_restart_ok", int'(seq_err_o), 0);
`endif

    started = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
